one_wire_master_engine: RTL and testbench

Parametrised 1-Wire master transaction engine. It generates reset/presence, write-slot and read-slot timing on an open-drain bus from a single command interface. Multi-byte frames of up to MAX_BYTES move through byte-level valid/ready handshakes, with a running Dallas CRC-8 check on read data. It replaces the fixed single-byte loopback transmitter/receiver pairing as the bus master used by the rest of the design.

---
 rtl/one_wire_master_engine_if.sv | 30 +++
 rtl/one_wire_master_engine.sv | 215 +++++++++++++++++++++
 tb/tb_one_wire_master_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/one_wire_master_engine_if.sv
// Command, byte-stream and open-drain bus signals of the 1-Wire master engine.
// The engine connects through the slave modport; the command issuer uses master.
interface one_wire_master_engine_if #(
  parameter int MAX_BYTES = 8
);
  logic                             cmd_valid;
  logic                             cmd_ready;
  logic [1:0]                       cmd_op;
  logic [$clog2(MAX_BYTES+1)-1:0]   cmd_len;
  logic                             wr_valid;
  logic                             wr_ready;
  logic [7:0]                       wr_data;
  logic                             rx_valid;
  logic [7:0]                       rx_data;
  logic                             done;
  logic                             presence;
  logic                             crc_ok;
  logic                             ow_drive_low;
  logic                             ow_in;

  modport master (
    output cmd_valid, cmd_op, cmd_len, wr_valid, wr_data, ow_in,
    input  cmd_ready, wr_ready, rx_valid, rx_data, done, presence, crc_ok, ow_drive_low
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, wr_valid, wr_data, ow_in,
    output cmd_ready, wr_ready, rx_valid, rx_data, done, presence, crc_ok, ow_drive_low
  );
endinterface

// File: rtl/one_wire_master_engine.sv
// 1-Wire master: reset/presence, write and read slots driven from one command port,
// with byte-level write/read streams and a running Dallas CRC-8 over read data.
module one_wire_master_engine #(
  parameter int TICK_DIV  = 50,
  parameter int MAX_BYTES = 8,
  parameter int T_RST     = 480,
  parameter int T_PRES    = 70,
  parameter int T_SLOT    = 60,
  parameter int T_LOW1    = 6,
  parameter int T_SAMPLE  = 15,
  parameter int T_REC     = 2
) (
  input  logic clk,
  input  logic rst,
  one_wire_master_engine_if.slave bus
);
  localparam int LW   = $clog2(MAX_BYTES + 1);
  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMX1 = (T_RST > T_SLOT) ? T_RST : T_SLOT;
  localparam int TMAX = (TMX1 > T_REC) ? TMX1 : T_REC;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, RST_LOW, RST_WAIT, BYTE_FETCH, SLOT_LOW, SLOT_REL, SLOT_REC, DONE
  } state_t;

  state_t         state;
  logic [PW-1:0]  presc;
  logic [TW-1:0]  tcnt;
  logic [1:0]     op;
  logic [LW-1:0]  len;
  logic [LW-1:0]  byte_cnt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic [7:0]     crc;
  logic           tick;
  logic           accept;
  logic           fetch_hs;
  logic           presc_clr;
  logic           is_read;
  logic           long_low;
  logic           last_byte;
  logic [TW-1:0]  low_end;
  logic [LW-1:0]  len_clamped;

  assign tick        = (presc == PW'(TICK_DIV - 1));
  assign accept      = bus.cmd_valid && bus.cmd_ready;
  assign fetch_hs    = (state == BYTE_FETCH) && bus.wr_ready && bus.wr_valid;
  assign presc_clr   = accept || fetch_hs;
  assign is_read     = (op == 2'b10);
  assign long_low    = !is_read && !shreg[0];
  assign low_end     = long_low ? TW'(T_SLOT - 1) : TW'(T_LOW1 - 1);
  assign last_byte   = (byte_cnt == len - LW'(1));
  assign len_clamped = (bus.cmd_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : bus.cmd_len;

  // Free-running prescaler, realigned whenever a slot sequence starts from rest
  // so every slot length is an exact multiple of TICK_DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    presc <= '0;
    else if (presc_clr || tick) presc <= '0;
    else                        presc <= presc + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tcnt             <= '0;
      op               <= '0;
      len              <= '0;
      byte_cnt         <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      crc              <= '0;
      bus.cmd_ready    <= 1'b1;
      bus.wr_ready     <= 1'b0;
      bus.rx_valid     <= 1'b0;
      bus.rx_data      <= '0;
      bus.done         <= 1'b0;
      bus.presence     <= 1'b0;
      bus.crc_ok       <= 1'b0;
      bus.ow_drive_low <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.cmd_ready <= 1'b0;
            op            <= bus.cmd_op;
            len           <= len_clamped;
            tcnt          <= '0;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            if (bus.cmd_op == 2'b10) crc <= '0;
            if (bus.cmd_op == 2'b00) begin
              state            <= RST_LOW;
              bus.ow_drive_low <= 1'b1;
            end else if (bus.cmd_op == 2'b11 || bus.cmd_len == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else if (bus.cmd_op == 2'b01) begin
              state <= BYTE_FETCH;
            end else begin
              state            <= SLOT_LOW;
              bus.ow_drive_low <= 1'b1;
            end
          end
        end
        RST_LOW: begin
          if (tick) begin
            if (tcnt == TW'(T_RST - 1)) begin
              tcnt             <= '0;
              state            <= RST_WAIT;
              bus.ow_drive_low <= 1'b0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        RST_WAIT: begin
          if (tick) begin
            if (tcnt == TW'(T_PRES - 1)) bus.presence <= ~bus.ow_in;
            if (tcnt == TW'(T_RST - 1)) begin
              tcnt     <= '0;
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        BYTE_FETCH: begin
          if (!bus.wr_ready) begin
            bus.wr_ready <= 1'b1;
          end else if (bus.wr_valid) begin
            bus.wr_ready     <= 1'b0;
            shreg            <= bus.wr_data;
            tcnt             <= '0;
            bit_cnt          <= '0;
            state            <= SLOT_LOW;
            bus.ow_drive_low <= 1'b1;
          end
        end
        // A write-0 holds the bus low for the whole slot, so it skips the released part.
        SLOT_LOW: begin
          if (tick) begin
            if (tcnt == low_end) begin
              bus.ow_drive_low <= 1'b0;
              if (long_low) begin
                state <= SLOT_REC;
                tcnt  <= '0;
              end else begin
                state <= SLOT_REL;
                tcnt  <= tcnt + TW'(1);
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        SLOT_REL: begin
          if (tick) begin
            if (is_read && tcnt == TW'(T_SAMPLE - 1)) begin
              shreg <= {bus.ow_in, shreg[7:1]};
              crc   <= (crc >> 1) ^ ((crc[0] ^ bus.ow_in) ? 8'h8C : 8'h00);
            end
            if (tcnt == TW'(T_SLOT - 1)) begin
              state <= SLOT_REC;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        SLOT_REC: begin
          if (tick) begin
            if (tcnt == TW'(T_REC - 1)) begin
              tcnt <= '0;
              if (!is_read) shreg <= shreg >> 1;
              if (bit_cnt != 3'd7) begin
                bit_cnt          <= bit_cnt + 3'd1;
                state            <= SLOT_LOW;
                bus.ow_drive_low <= 1'b1;
              end else begin
                bit_cnt  <= '0;
                byte_cnt <= byte_cnt + LW'(1);
                if (is_read) begin
                  bus.rx_data  <= shreg;
                  bus.rx_valid <= 1'b1;
                end
                if (last_byte) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                  if (is_read) bus.crc_ok <= (crc == 8'h00);
                end else if (is_read) begin
                  state            <= SLOT_LOW;
                  bus.ow_drive_low <= 1'b1;
                end else begin
                  state <= BYTE_FETCH;
                end
              end
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        DONE: begin
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_one_wire_master_engine.sv
// Scoreboard bench for one_wire_master_engine: a bus-level slave model decodes and
// answers slots, while a monitor checks rx bytes and command completions against a queue.
`timescale 1ns/1ps
module tb_one_wire_master_engine;
  localparam int TD       = 2;
  localparam int CLK_NS   = 10;
  localparam int SLOT_CLK = (60 + 2) * TD;

  typedef struct {
    logic presence;
    logic crc_ok;
    logic with_rx;
  } done_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic slave_pull = 1'b0;

  always #5 clk = ~clk;

  one_wire_master_engine_if #(.MAX_BYTES(8)) bus();
  assign bus.ow_in = ~(bus.ow_drive_low | slave_pull);

  one_wire_master_engine #(
    .TICK_DIV(TD), .MAX_BYTES(8), .T_RST(480), .T_PRES(70), .T_SLOT(60),
    .T_LOW1(6), .T_SAMPLE(15), .T_REC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  done_exp_t  exp_done[$];
  logic [7:0] exp_rx[$];
  logic       exp_bits[$];
  logic       rd_bits[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic model_presence = 1'b0;
  logic model_crc_ok = 1'b0;
  bit   done_seen = 1'b0;
  bit   aborting = 1'b0;
  bit   slave_present = 1'b0;
  time  t_done = 0;
  time  t_release = 0;
  time  prev_slot_t = 0;
  int   reset_width = 0;
  int   slot_starts = 0;
  int   wr_slot_idx = 0;
  int   wr_rises = 0;
  logic [7:0] fixed_vec [8] = '{8'h02, 8'h1C, 8'hB8, 8'h01, 8'h00, 8'h00, 8'h00, 8'hA2};

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] d[$]);
    logic [7:0] c;
    logic [7:0] b;
    logic       mix;
    c = 8'h00;
    foreach (d[i]) begin
      b = d[i];
      for (int k = 0; k < 8; k++) begin
        mix = c[0] ^ b[0];
        c   = c >> 1;
        if (mix) c = c ^ 8'h8C;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  always @(posedge bus.wr_ready) wr_rises++;
  always @(posedge bus.done) t_done = $time;

  // Monitor: every rx_valid and done the DUT presents is matched against the queues.
  done_exp_t mon_d;
  logic [7:0] mon_rx;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL rx_unexpected: got rx_data=%02h, required no rx_valid", bus.rx_data);
        end else begin
          mon_rx = exp_rx.pop_front();
          check_output("rx_data", bus.rx_data, mon_rx);
        end
      end
      if (bus.done) begin
        done_seen = 1'b1;
        if (exp_done.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL done_unexpected: got done=1, required no done");
        end else begin
          mon_d = exp_done.pop_front();
          check_output("presence", bus.presence, mon_d.presence);
          check_output("crc_ok", bus.crc_ok, mon_d.crc_ok);
          if (mon_d.with_rx) check_output("rx_with_done", bus.rx_valid, 1);
        end
      end
    end
  end

  // Slave model: answers read slots from rd_bits, otherwise measures low pulses.
  logic sl_b;
  time  sl_t;
  int   sl_w;
  initial begin
    forever begin
      @(posedge bus.ow_drive_low);
      sl_t = $time;
      slot_starts++;
      if (rd_bits.size() > 0) begin
        sl_b = rd_bits.pop_front();
        if (!sl_b) begin
          slave_pull = 1'b1;
          repeat (30 * TD) @(posedge clk);
          slave_pull = 1'b0;
        end
      end else begin
        @(negedge bus.ow_drive_low);
        sl_w      = int'(($time - sl_t) / CLK_NS);
        t_release = $time;
        if (aborting) begin
          wr_slot_idx = 0;
        end else if (sl_w >= 400 * TD) begin
          reset_width = sl_w;
          if (slave_present) begin
            repeat (30 * TD) @(posedge clk);
            slave_pull = 1'b1;
            repeat (100 * TD) @(posedge clk);
            slave_pull = 1'b0;
          end
        end else if (exp_bits.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL wr_slot_unexpected: got low pulse of %0d clk, required none", sl_w);
        end else begin
          sl_b = exp_bits.pop_front();
          check_output("wr_low_width", sl_w, sl_b ? 6 * TD : 60 * TD);
          if (wr_slot_idx % 8 != 0)
            check_output("wr_slot_period", int'((sl_t - prev_slot_t) / CLK_NS), SLOT_CLK);
          prev_slot_t = sl_t;
          wr_slot_idx++;
        end
      end
    end
  end

  task automatic wait_done(input int limit, input string name);
    int c;
    c = 0;
    while (!done_seen && c < limit) begin
      @(posedge clk);
      c++;
    end
    #1;
    if (!done_seen) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_timeout: got no done within %0d cycles, required done", name, limit);
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input int len);
    check_output("cmd_ready_idle", bus.cmd_ready, 1);
    done_seen   = 1'b0;
    bus.cmd_op  = op;
    bus.cmd_len = 4'(len);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic do_reset_cmd(input bit present);
    slave_present  = present;
    model_presence = present;
    exp_done.push_back('{present, model_crc_ok, 1'b0});
    issue_cmd(2'b00, 0);
    check_output("rst_first_low", bus.ow_drive_low, 1);
    wait_done(2 * 480 * TD + 200, "reset");
    check_output("rst_low_width", reset_width, 480 * TD);
    check_output("rst_release_window", int'((t_done - t_release) / CLK_NS), 480 * TD);
  endtask

  task automatic do_write(input logic [7:0] bytes[$], input int stall_idx, input int stall_cycles);
    int r0;
    int c;
    int bad;
    r0 = wr_rises;
    exp_done.push_back('{model_presence, model_crc_ok, 1'b0});
    issue_cmd(2'b01, bytes.size());
    foreach (bytes[i]) begin
      c = 0;
      while (!bus.wr_ready && c < 2000) begin
        @(posedge clk);
        #1;
        c++;
      end
      check_output("wr_ready_wait", bus.wr_ready, 1);
      if (i == stall_idx) begin
        bad = 0;
        repeat (stall_cycles) begin
          @(posedge clk);
          #1;
          if (bus.ow_drive_low) bad++;
        end
        check_output("stall_released", bad, 0);
      end
      for (int k = 0; k < 8; k++) exp_bits.push_back(bytes[i][k]);
      bus.wr_data  = bytes[i];
      bus.wr_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      check_output("wr_ready_fall", bus.wr_ready, 0);
      check_output("wr_first_low", bus.ow_drive_low, 1);
    end
    wait_done(8 * SLOT_CLK + 200, "write");
    check_output("wr_bits_left", exp_bits.size(), 0);
    check_output("wr_ready_count", wr_rises - r0, bytes.size());
  endtask

  task automatic do_read(input logic [7:0] bytes[$], input int len);
    int s0;
    foreach (bytes[i]) begin
      exp_rx.push_back(bytes[i]);
      for (int k = 0; k < 8; k++) rd_bits.push_back(bytes[i][k]);
    end
    if (bytes.size() > 0) model_crc_ok = (crc8(bytes) == 8'h00);
    exp_done.push_back('{model_presence, model_crc_ok, bytes.size() > 0});
    s0 = slot_starts;
    issue_cmd(2'b10, len);
    if (bytes.size() == 0) begin
      check_output("len0_done_now", bus.done, 1);
      check_output("len0_bus_idle", bus.ow_drive_low, 0);
    end else begin
      check_output("rd_first_low", bus.ow_drive_low, 1);
    end
    wait_done(bytes.size() * 8 * SLOT_CLK + 200, "read");
    check_output("rx_count_left", exp_rx.size(), 0);
    if (bytes.size() == 0) check_output("len0_no_slots", slot_starts - s0, 0);
  endtask

  task automatic do_abort();
    int c;
    int s0;
    s0 = slot_starts;
    issue_cmd(2'b01, 1);
    c = 0;
    while (!bus.wr_ready && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    for (int k = 0; k < 8; k++) exp_bits.push_back(1'b0);
    bus.wr_data  = 8'h00;
    bus.wr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    c = 0;
    while (slot_starts < s0 + 4 && c < 2000) begin
      @(posedge clk);
      c++;
    end
    repeat (20) @(posedge clk);
    #1;
    check_output("abort_mid_low", bus.ow_drive_low, 1);
    aborting = 1'b1;
    rst = 1'b1;
    #1;
    check_output("abort_drive_released", bus.ow_drive_low, 0);
    check_output("abort_cmd_ready", bus.cmd_ready, 1);
    exp_bits.delete();
    model_presence = 1'b0;
    model_crc_ok   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("abort_ready_after", bus.cmd_ready, 1);
    repeat (300) @(posedge clk);
    #1;
    check_output("abort_no_done", done_seen, 0);
    aborting = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] q[$];
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_cmd_ready", bus.cmd_ready, 1);
    check_output("rst_wr_ready", bus.wr_ready, 0);
    check_output("rst_rx_valid", bus.rx_valid, 0);
    check_output("rst_done", bus.done, 0);
    check_output("rst_presence", bus.presence, 0);
    check_output("rst_crc_ok", bus.crc_ok, 0);
    check_output("rst_drive", bus.ow_drive_low, 0);
    check_output("rst_rx_data", bus.rx_data, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] bus reset with and without a slave");
    do_reset_cmd(1'b1);
    do_reset_cmd(1'b0);

    $display("[TB] writes");
    q.delete(); q.push_back(8'hA5);
    do_write(q, -1, 0);
    q.delete(); q.push_back(8'($urandom_range(0, 255))); q.push_back(8'h3C);
    do_write(q, 1, 500);
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 255)));
    do_write(q, -1, 0);

    $display("[TB] reads");
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(fixed_vec[i]);
    do_read(q, 8);
    q[5] = q[5] ^ 8'h08;
    do_read(q, 8);
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(8'($urandom_range(0, 255)));
    q.push_back(crc8(q));
    do_read(q, 4);
    q.delete();
    for (int i = 0; i < 2; i++) q.push_back(8'($urandom_range(0, 255)));
    do_read(q, 2);
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom_range(0, 255)));
    do_read(q, 11);

    $display("[TB] zero-length and reserved commands");
    q.delete();
    do_read(q, 0);
    exp_done.push_back('{model_presence, model_crc_ok, 1'b0});
    issue_cmd(2'b11, 5);
    check_output("reserved_done_now", bus.done, 1);
    wait_done(10, "reserved");

    $display("[TB] reset during a write slot");
    do_abort();
    do_reset_cmd(1'b1);

    check_output("done_queue_empty", exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
